io_arbiter: RTL and testbench
=============================

# io_arbiter

Shares the single memory-mapped I/O bus (LEDs, hex displays, UART, PS/2, GPIO/SD, frame-buffer base register) between several requesters, such as the processor core and a host debug/loader port. It sits between the requesters and the top-level I/O address decode and read-data mux. Each request is serialized into exactly one target-bus transaction, and the arbiter returns read data and an acknowledge to the winning requester. Arbitration is round-robin, so no requester starves.

## Interface

Parameters:
- NUM_REQUESTERS, default 2: number of requesters; legal range 2..8.
- ADDR_WIDTH, default 32: I/O address width.

Ports (clock and reset first):
- clk, input, 1: single clock for all logic.
- reset_n, input, 1: reset, asynchronous and active-low.
- req_write_en, input, NUM_REQUESTERS: per-requester write request.
- req_read_en, input, NUM_REQUESTERS: per-requester read request.
- req_address, input, NUM_REQUESTERS*ADDR_WIDTH: packed addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_write_data, input, NUM_REQUESTERS*32: packed write data; requester k uses bits [k*32 +: 32].
- req_ack, output, NUM_REQUESTERS: one-hot, one-cycle completion pulse.
- req_read_data, output, 32: read data for the requester currently acknowledged.
- io_write_en, output, 1: target-bus write strobe.
- io_read_en, output, 1: target-bus read strobe.
- io_address, output, ADDR_WIDTH: target-bus address.
- io_write_data, output, 32: target-bus write data.
- io_read_data, input, 32: target read data, valid exactly one cycle after the io_read_en cycle.

## Operation

- A request from requester k is pending while req_write_en[k] or req_read_en[k] is high.
- The requester holds address, data and enables stable until it sees req_ack[k]. It drops or changes them in the cycle after the ack.
- State machine:
  - IDLE to ISSUE: taken when any unmasked request is pending. The arbiter latches the winner index, address, write data, and both enables into registers.
  - ISSUE to CAPTURE: unconditional. io_* outputs carry the latched transaction for exactly this one cycle.
  - CAPTURE to IDLE: unconditional. The arbiter registers io_read_data into req_read_data and sets req_ack[winner] for the next cycle.
- Round-robin arbitration:
  - A pointer last_grant drives the search. The search starts at (last_grant+1) mod NUM_REQUESTERS and the first pending requester wins.
  - last_grant updates on every transition to ISSUE.
  - At reset last_grant = NUM_REQUESTERS-1, so requester 0 has the highest priority first.
- Masking: in the cycle req_ack[k] is high, requester k's inputs are ignored by arbitration. Its enables may still be high from the completed request. Other requesters may win in that cycle.
- Write-only transactions still pass through CAPTURE. req_read_data then returns whatever io_read_data held and is don't-care to the requester.
- If both write and read enables are high, both are forwarded together in ISSUE and the read data is returned.
- io_write_en and io_read_en are 0 in every state except ISSUE.
- io_address and io_write_data hold their last latched value outside ISSUE.

## Timing

- Reset values (asynchronous, effective while reset_n = 0):
  - state = IDLE, last_grant = NUM_REQUESTERS-1.
  - io_write_en = 0, io_read_en = 0, io_address = 0, io_write_data = 0.
  - req_ack = 0, req_read_data = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency for a request first seen in IDLE at cycle 0:
  - cycle 1: ISSUE, io strobe high.
  - cycle 2: CAPTURE, io_read_data sampled at the end of the cycle.
  - cycle 3: req_ack high, req_read_data valid.
- Peak throughput is one transaction per 3 cycles. The next ISSUE can occur in cycle 4, because the ack cycle is also an IDLE arbitration cycle.
- Simultaneous new requests are resolved by the round-robin rule only; requester arrival order is irrelevant.
- If reset_n is asserted mid-transaction, the transaction is abandoned. The strobe drops immediately (asynchronously), no ack is issued, and the requester must reissue after reset.
- A request that deasserts before being granted is dropped without an ack. This is legal only for requesters that tolerate it; the core never does it.

## Test plan

- Single read: requester 0 reads 'h18 with target returning 32'h0000_0041 one cycle after the strobe. Required: io_read_en high for exactly 1 cycle at cycle 1, req_ack = 2'b01 at cycle 3, req_read_data = 32'h41.
- Single write: requester 1 writes 32'h3_FFFF to 'h00. Required: io_write_en = 1 with io_address = 'h00 and io_write_data = 32'h3_FFFF for exactly 1 cycle, and req_ack = 2'b10 at cycle 3.
- Contention after reset: both requesters request in the same cycle. Required: requester 0 is served first (ack at cycle 3), then requester 1 (strobe at cycle 4, ack at cycle 6). With both held continuously, grants alternate 0,1,0,1.
- Ack masking: requester 0 keeps its enables high during its ack cycle with no other requests pending. Required: no second transaction is issued from that ack cycle; a new ISSUE for requester 0 occurs only if the request is still high in the following cycle.
- Reset mid-operation: reset_n is pulled low during ISSUE. Required: io_write_en and io_read_en are 0 immediately, req_ack stays 0, and after reset release the first request from requester 0 completes in 3 cycles.
- NUM_REQUESTERS = 4 with all four requesting continuously. Required: grant order is 0,1,2,3,0 and each requester gets exactly one ack per 12 cycles.

Source files
------------

// File: rtl/io_arbiter_if.sv
// Requester-side and target-side I/O bus signals of the round-robin I/O arbiter.
interface io_arbiter_if #(
  parameter int NUM_REQUESTERS = 2,
  parameter int ADDR_WIDTH     = 32
);
  logic [NUM_REQUESTERS-1:0]            req_write_en;
  logic [NUM_REQUESTERS-1:0]            req_read_en;
  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_REQUESTERS*32-1:0]         req_write_data;
  logic [NUM_REQUESTERS-1:0]            req_ack;
  logic [31:0]                          req_read_data;
  logic                                 io_write_en;
  logic                                 io_read_en;
  logic [ADDR_WIDTH-1:0]                io_address;
  logic [31:0]                          io_write_data;
  logic [31:0]                          io_read_data;

  // Arbiter side
  modport slave (
    input  req_write_en, req_read_en, req_address, req_write_data, io_read_data,
    output req_ack, req_read_data, io_write_en, io_read_en, io_address, io_write_data
  );

  // Requesters plus target side
  modport master (
    output req_write_en, req_read_en, req_address, req_write_data, io_read_data,
    input  req_ack, req_read_data, io_write_en, io_read_en, io_address, io_write_data
  );
endinterface

// File: rtl/io_arbiter.sv
// Round-robin arbiter serializing requester transactions onto the shared I/O bus.
// One transaction per IDLE -> ISSUE -> CAPTURE pass; ack lands in the following IDLE.
module io_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  io_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          last_grant;
  logic [NUM_REQUESTERS-1:0] pending;
  logic                      found;
  logic [IDX_W-1:0]          pick;

  // A requester being acked may still show its finished request; ignore it this cycle.
  assign pending = (bus.req_write_en | bus.req_read_en) & ~bus.req_ack;

  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQUESTERS;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      last_grant        <= IDX_W'(NUM_REQUESTERS - 1);
      bus.io_write_en   <= 1'b0;
      bus.io_read_en    <= 1'b0;
      bus.io_address    <= '0;
      bus.io_write_data <= '0;
      bus.req_ack       <= '0;
      bus.req_read_data <= '0;
    end else begin
      bus.req_ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state             <= ISSUE;
            last_grant        <= pick;
            bus.io_write_en   <= bus.req_write_en[pick];
            bus.io_read_en    <= bus.req_read_en[pick];
            bus.io_address    <= bus.req_address[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.io_write_data <= bus.req_write_data[int'(pick)*32 +: 32];
          end
        end
        ISSUE: begin
          state           <= CAPTURE;
          bus.io_write_en <= 1'b0;
          bus.io_read_en  <= 1'b0;
        end
        CAPTURE: begin
          // Target read data is valid in the cycle after the strobe.
          state                   <= IDLE;
          bus.req_read_data       <= bus.io_read_data;
          bus.req_ack[last_grant] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: 2-requester and 4-requester instances sharing clk/reset.
module tb_io_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_arbiter_if #(.NUM_REQUESTERS(2), .ADDR_WIDTH(32)) b2 ();
  io_arbiter_if #(.NUM_REQUESTERS(4), .ADDR_WIDTH(32)) b4 ();

  io_arbiter #(.NUM_REQUESTERS(2), .ADDR_WIDTH(32)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));
  io_arbiter #(.NUM_REQUESTERS(4), .ADDR_WIDTH(32)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));

  // Target model: read data = address + 'h29, one cycle after the read strobe.
  always @(posedge clk) if (b2.io_read_en) b2.io_read_data <= b2.io_address + 32'h29;
  always @(posedge clk) if (b4.io_read_en) b4.io_read_data <= b4.io_address + 32'h29;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    b2.req_write_en = '0; b2.req_read_en = '0;
    b4.req_write_en = '0; b4.req_read_en = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if (b2.io_write_en !== 1'b0 || b2.io_read_en !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got we=%b re=%b want 0 0", b2.io_write_en, b2.io_read_en);
    end
    checks++;
    if (b2.io_address !== 32'h0 || b2.io_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_bus got addr=%h wd=%h want 0 0", b2.io_address, b2.io_write_data);
    end
    checks++;
    if (b2.req_ack !== 2'b00 || b2.req_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_ack got ack=%b rd=%h want 00 0", b2.req_ack, b2.req_read_data);
    end
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    b2.req_address[0 +: 32] = 32'h18;
    b2.req_read_en[0] = 1'b1;
    step();  // cycle 1
    checks++;
    if (b2.io_read_en !== 1'b1 || b2.io_write_en !== 1'b0 || b2.io_address !== 32'h18) begin
      errors++; $display("FAIL read_issue got re=%b we=%b addr=%h want 1 0 18", b2.io_read_en, b2.io_write_en, b2.io_address);
    end
    step();  // cycle 2
    checks++;
    if (b2.io_read_en !== 1'b0 || b2.req_ack !== 2'b00) begin
      errors++; $display("FAIL read_capture got re=%b ack=%b want 0 00", b2.io_read_en, b2.req_ack);
    end
    step();  // cycle 3
    checks++;
    if (b2.req_ack !== 2'b01 || b2.req_read_data !== 32'h41) begin
      errors++; $display("FAIL read_ack got ack=%b rd=%h want 01 00000041", b2.req_ack, b2.req_read_data);
    end
    b2.req_read_en[0] = 1'b0;
    step();
    checks++;
    if (b2.req_ack !== 2'b00 || b2.io_read_en !== 1'b0) begin
      errors++; $display("FAIL read_after got ack=%b re=%b want 00 0", b2.req_ack, b2.io_read_en);
    end
  endtask

  task automatic test_single_write();
    b2.req_address[32 +: 32]    = 32'h0;
    b2.req_write_data[32 +: 32] = 32'h0003_FFFF;
    b2.req_write_en[1] = 1'b1;
    step();
    checks++;
    if (b2.io_write_en !== 1'b1 || b2.io_read_en !== 1'b0 || b2.io_address !== 32'h0 || b2.io_write_data !== 32'h0003_FFFF) begin
      errors++; $display("FAIL write_issue got we=%b re=%b addr=%h wd=%h want 1 0 0 0003ffff",
                         b2.io_write_en, b2.io_read_en, b2.io_address, b2.io_write_data);
    end
    step();
    checks++;
    if (b2.io_write_en !== 1'b0 || b2.io_write_data !== 32'h0003_FFFF) begin
      errors++; $display("FAIL write_one_cycle got we=%b wd=%h want 0 0003ffff", b2.io_write_en, b2.io_write_data);
    end
    step();
    checks++;
    if (b2.req_ack !== 2'b10) begin
      errors++; $display("FAIL write_ack got %b want 10", b2.req_ack);
    end
    b2.req_write_en[1] = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_ack;
    logic [31:0] exp_addr;
    do_reset();
    b2.req_address = {32'h20, 32'h10};
    b2.req_read_en = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_ack  = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b01 : 2'b10);
      exp_addr = (((c - 1) / 3) % 2 == 0) ? 32'h10 : 32'h20;
      checks++;
      if (b2.io_read_en !== (c % 3 == 1) || b2.req_ack !== exp_ack) begin
        errors++; $display("FAIL contention_c%0d got re=%b ack=%b want %b %b", c, b2.io_read_en, b2.req_ack, (c % 3 == 1), exp_ack);
      end
      if (c % 3 == 1) begin
        checks++;
        if (b2.io_address !== exp_addr) begin
          errors++; $display("FAIL contention_addr_c%0d got %h want %h", c, b2.io_address, exp_addr);
        end
      end
      if (c % 3 == 0) begin
        checks++;
        if (b2.req_read_data !== exp_addr + 32'h29) begin
          errors++; $display("FAIL contention_rd_c%0d got %h want %h", c, b2.req_read_data, exp_addr + 32'h29);
        end
      end
    end
    b2.req_read_en = 2'b00;
    step();
    step();
  endtask

  task automatic test_ack_mask();
    b2.req_address[0 +: 32] = 32'h30;
    b2.req_read_en[0] = 1'b1;
    step(); step(); step();  // cycle 3: ack, enables still high
    checks++;
    if (b2.req_ack !== 2'b01) begin
      errors++; $display("FAIL mask_ack got %b want 01", b2.req_ack);
    end
    step();  // cycle 4: masked in cycle 3, so no strobe
    checks++;
    if (b2.io_read_en !== 1'b0 || b2.io_write_en !== 1'b0) begin
      errors++; $display("FAIL mask_no_issue got re=%b we=%b want 0 0", b2.io_read_en, b2.io_write_en);
    end
    step();  // cycle 5: still high in cycle 4 -> new ISSUE
    checks++;
    if (b2.io_read_en !== 1'b1 || b2.io_address !== 32'h30) begin
      errors++; $display("FAIL mask_reissue got re=%b addr=%h want 1 30", b2.io_read_en, b2.io_address);
    end
    b2.req_read_en[0] = 1'b0;
    step(); step();  // cycle 7
    checks++;
    if (b2.req_ack !== 2'b01) begin
      errors++; $display("FAIL mask_ack2 got %b want 01", b2.req_ack);
    end
    step(); step();
    checks++;
    if (b2.io_read_en !== 1'b0 || b2.req_ack !== 2'b00) begin
      errors++; $display("FAIL mask_quiet got re=%b ack=%b want 0 00", b2.io_read_en, b2.req_ack);
    end
  endtask

  task automatic test_reset_mid();
    b2.req_address[0 +: 32]    = 32'h08;
    b2.req_write_data[0 +: 32] = 32'hA5A5_0001;
    b2.req_write_en[0] = 1'b1;
    step();
    checks++;
    if (b2.io_write_en !== 1'b1) begin
      errors++; $display("FAIL midreset_issue got we=%b want 1", b2.io_write_en);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (b2.io_write_en !== 1'b0 || b2.io_read_en !== 1'b0) begin
      errors++; $display("FAIL midreset_async got we=%b re=%b want 0 0", b2.io_write_en, b2.io_read_en);
    end
    step(); step(); step();
    checks++;
    if (b2.req_ack !== 2'b00) begin
      errors++; $display("FAIL midreset_noack got %b want 00", b2.req_ack);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (b2.io_write_en !== 1'b1 || b2.io_address !== 32'h08) begin
      errors++; $display("FAIL midreset_reissue got we=%b addr=%h want 1 08", b2.io_write_en, b2.io_address);
    end
    step(); step();
    checks++;
    if (b2.req_ack !== 2'b01) begin
      errors++; $display("FAIL midreset_ack got %b want 01", b2.req_ack);
    end
    b2.req_write_en[0] = 1'b0;
    step();
  endtask

  task automatic test_four();
    logic [3:0]  exp_ack;
    logic [31:0] exp_addr;
    int          acks [4];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      b4.req_address[k*32 +: 32] = 32'h100 + 32'(k * 4);
      acks[k] = 0;
    end
    b4.req_read_en = 4'hF;
    for (int c = 1; c <= 15; c++) begin
      step();
      exp_ack  = (c % 3 == 0) ? 4'(1 << (((c / 3) - 1) % 4)) : 4'h0;
      exp_addr = 32'h100 + 32'((((c - 1) / 3) % 4) * 4);
      checks++;
      if (b4.io_read_en !== (c % 3 == 1) || b4.req_ack !== exp_ack) begin
        errors++; $display("FAIL four_c%0d got re=%b ack=%b want %b %b", c, b4.io_read_en, b4.req_ack, (c % 3 == 1), exp_ack);
      end
      if (c % 3 == 1) begin
        checks++;
        if (b4.io_address !== exp_addr) begin
          errors++; $display("FAIL four_addr_c%0d got %h want %h", c, b4.io_address, exp_addr);
        end
      end
      if (c <= 12) for (int k = 0; k < 4; k++) if (b4.req_ack[k]) acks[k]++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (acks[k] != 1) begin
        errors++; $display("FAIL four_acks_r%0d got %0d want 1", k, acks[k]);
      end
    end
    b4.req_read_en = 4'h0;
    step(); step();
  endtask

  initial begin
    clear_reqs();
    b2.req_address = '0; b2.req_write_data = '0; b2.io_read_data = '0;
    b4.req_address = '0; b4.req_write_data = '0; b4.io_read_data = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_ack_mask();
    test_reset_mid();
    test_four();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
